sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
Two-port arbiter that shares the single SDRAM platform external bus (address/read/write/write_data/acknowledge/read_data) between requesters. Port 0 is the CPU-side path; port 1 is a secondary master (DMA/video fetch). It latches each requester's command and drives exactly one bus transaction at a time, holding the strobe until the bus acknowledges. It returns read data and a one-cycle ack to the winning port. Runs entirely in the clk_50 domain, between the requesters and the SDRAM platform instance.

Parameters:
ADDR_W, 16, address width of requesters and bus
DATA_W, 8, data width
TIMEOUT, 255, max cycles a strobe is held waiting for bus_acknowledge before abort (>=2)

Ports:
clk_50  in  1  system clock
rst  in  1  synchronous active-high reset
m0_req  in  1  port 0 request, level, held until m0_ack
m0_we  in  1  port 0 write (1) / read (0)
m0_addr  in  ADDR_W  port 0 address
m0_wdata  in  DATA_W  port 0 write data
m0_ack  out  1  port 0 completion pulse, 1 cycle
m0_err  out  1  port 0 timeout flag, valid with m0_ack
m0_rdata  out  DATA_W  port 0 read data, held until next port 0 completion
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata  as port 0, for port 1
bus_address  out  ADDR_W  to ext_bus address
bus_read  out  1  to ext_bus read
bus_write  out  1  to ext_bus write
bus_write_data  out  DATA_W  to ext_bus write_data
bus_byte_enable  out  1  constant 1
bus_acknowledge  in  1  from ext_bus acknowledge
bus_read_data  in  DATA_W  from ext_bus read_data
grant  out  2  one-hot owner of current transaction, 0 when idle
busy  out  1  high in ISSUE and RESP

Behaviour:
- Reset: synchronous to clk_50, active-high. All outputs 0 except bus_byte_enable=1; state IDLE; last_served=1, so port 0 wins first; timeout counter 0; rdata registers 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: evaluate eligible requests.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the port != last_served (round-robin).
  - Grant edge: latch we/addr/wdata of the winner into command registers, set grant, go to ISSUE.
  - No request: stay in IDLE.
- Eligibility: req high, except that the port served in the preceding RESP is ignored in the first IDLE cycle after RESP. This gives the requester time to drop req after its ack.
- ISSUE:
  - Outputs: bus_read=~we or bus_write=we, both registered. bus_address/bus_write_data come from the latched command and stay stable the whole state.
  - Counter increments each cycle.
  - On bus_acknowledge: capture bus_read_data if read, strobes low on the next edge, err_flag=0, go to RESP.
  - If the counter reaches TIMEOUT without ack: strobes low, err_flag=1, rdata forced to all-ones for reads, go to RESP.
  - Ack and timeout in the same cycle: ack wins, err=0.
- RESP (1 cycle):
  - Granted port's mX_ack=1 and mX_err=err_flag; mX_rdata updated (reads only; writes leave it unchanged).
  - last_served=granted port; grant cleared on exit; go to IDLE.
- Latency, uncontended read: req sampled in IDLE at edge T; strobe high in cycle T+1; ack arrives in cycle T+k; mX_ack high in cycle T+k+1; IDLE at T+k+2. Minimum turnaround is 3 cycles per transaction plus bus latency.
- Bus strobe rules:
  - bus_read and bus_write are never high together.
  - Strobes are never high outside ISSUE.
  - Strobes drop in the cycle after acknowledge is sampled, so one strobe produces exactly one bus access.
- Requester rules:
  - req dropped while its transaction is in ISSUE: the transaction still completes and ack still pulses.
  - req/addr changes after the grant edge are ignored.
- Reset mid-transaction: strobes, ack and grant go low at the next edge; no completion pulse; any late bus_acknowledge is ignored in IDLE.
- Counter width: clog2(TIMEOUT+1); it saturates and is cleared on entry to ISSUE.

Decomposition:
- Shared package sdram_pkg:
  - arb_state_t enum (IDLE, ISSUE, RESP)
  - port index constants PORT_CPU=0, PORT_AUX=1
  - all-ones read-error data constant
- One sub-module is natural: sdram_rr_pick. It is combinational: takes two eligible bits and last_served, returns a one-hot winner. It is reusable if the port count grows.

Test Plan:
- Single read: m0_req, m0_we=0, addr=16'h1234; bus_acknowledge 3 cycles after strobe with read_data=8'hA5 -> bus_read high exactly 3 cycles, bus_address=16'h1234, m0_ack 1 cycle with m0_rdata=8'hA5, m0_err=0.
- Single write: m1 write addr=16'h00FF, wdata=8'h3C; ack after 1 cycle -> bus_write 1 cycle, bus_write_data=8'h3C, bus_read never high, m1_ack pulse, m1_rdata unchanged.
- Contention: m0 and m1 requesting continuously from reset, each ack after 2 cycles -> grant order 0,1,0,1 over 4 transactions; no port served twice in a row.
- Timeout: m0 read, bus_acknowledge never asserted, TIMEOUT=8 -> strobe high 8 cycles then low, m0_ack with m0_err=1, m0_rdata=8'hFF; the next m1 request is served normally.
- Reset mid-ISSUE: assert rst while bus_write is high -> next edge all strobes/grant/ack 0; a late bus_acknowledge after rst release produces no mX_ack.
- Ack/timeout same cycle: TIMEOUT=4, ack on the 4th strobe cycle with data=8'h5A -> m0_err=0, m0_rdata=8'h5A.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types and constants for the two-port SDRAM bus arbiter.
package sdram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   localparam int PORT_CPU = 0;
   localparam int PORT_AUX = 1;

   // Fill pattern returned to a reader whose bus access timed out (sliced to DATA_W).
   localparam logic [63:0] RD_ERR_DATA = '1;

endpackage

// File: rtl/sdram_rr_pick.sv
// Two-way round-robin picker: one-hot winner from eligible bits and the last served port.
module sdram_rr_pick
   import sdram_pkg::*;
(
   input  logic [1:0] elig,
   input  logic       last_served,
   output logic [1:0] win
);

   always_comb begin
      win = 2'b00;
      if (elig == 2'b11) begin
         if (last_served) win[PORT_CPU] = 1'b1;
         else             win[PORT_AUX] = 1'b1;
      end else begin
         win = elig;
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM platform bus between CPU (port 0) and an auxiliary master (port 1),
// one strobed transaction at a time with a bounded wait for bus_acknowledge.
//
//   state | meaning
//   IDLE  | pick an eligible requester, latch its command
//   ISSUE | strobe held on the bus until acknowledge or timeout
//   RESP  | one-cycle completion pulse to the granted port
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_50,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic              m0_err,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic              m1_err,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] bus_address,
   output logic              bus_read,
   output logic              bus_write,
   output logic [DATA_W-1:0] bus_write_data,
   output logic              bus_byte_enable,
   input  logic              bus_acknowledge,
   input  logic [DATA_W-1:0] bus_read_data,
   output logic [1:0]        grant,
   output logic              busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   arb_state_t        state;
   logic [1:0]        grant_q;
   logic              last_served;
   logic              after_resp;
   logic              cmd_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        req;
   logic [1:0]        served_mask;
   logic [1:0]        elig;
   logic [1:0]        win;
   logic              done;
   logic [DATA_W-1:0] resp_data;

   assign req = {m1_req, m0_req};

   // The port just served gets one IDLE cycle to drop its request before it can win again.
   assign served_mask = after_resp ? (last_served ? 2'b10 : 2'b01) : 2'b00;
   assign elig        = req & ~served_mask;

   sdram_rr_pick u_pick (
      .elig        (elig),
      .last_served (last_served),
      .win         (win)
   );

   // Acknowledge takes priority over a timeout landing in the same cycle.
   assign done      = bus_acknowledge || (cnt == CNT_W'(TIMEOUT - 1));
   assign resp_data = bus_acknowledge ? bus_read_data : RD_ERR_DATA[DATA_W-1:0];

   assign bus_address     = cmd_addr;
   assign bus_write_data  = cmd_wdata;
   assign bus_byte_enable = 1'b1;
   assign grant           = grant_q;
   assign busy            = (state != IDLE);

   always_ff @(posedge clk_50) begin
      if (rst) begin
         state       <= IDLE;
         grant_q     <= 2'b00;
         last_served <= 1'b1;
         after_resp  <= 1'b0;
         cmd_we      <= 1'b0;
         cmd_addr    <= '0;
         cmd_wdata   <= '0;
         cnt         <= '0;
         bus_read    <= 1'b0;
         bus_write   <= 1'b0;
         m0_ack      <= 1'b0;
         m0_err      <= 1'b0;
         m0_rdata    <= '0;
         m1_ack      <= 1'b0;
         m1_err      <= 1'b0;
         m1_rdata    <= '0;
      end else begin
         after_resp <= (state == RESP);
         case (state)
            IDLE: begin
               if (|win) begin
                  grant_q   <= win;
                  cmd_we    <= win[PORT_AUX] ? m1_we    : m0_we;
                  cmd_addr  <= win[PORT_AUX] ? m1_addr  : m0_addr;
                  cmd_wdata <= win[PORT_AUX] ? m1_wdata : m0_wdata;
                  bus_read  <= win[PORT_AUX] ? ~m1_we   : ~m0_we;
                  bus_write <= win[PORT_AUX] ? m1_we    : m0_we;
                  cnt       <= '0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (cnt != CNT_W'(TIMEOUT)) cnt <= cnt + 1'b1;
               if (done) begin
                  bus_read  <= 1'b0;
                  bus_write <= 1'b0;
                  state     <= RESP;
                  if (grant_q[PORT_CPU]) begin
                     m0_ack <= 1'b1;
                     m0_err <= ~bus_acknowledge;
                     if (!cmd_we) m0_rdata <= resp_data;
                  end
                  if (grant_q[PORT_AUX]) begin
                     m1_ack <= 1'b1;
                     m1_err <= ~bus_acknowledge;
                     if (!cmd_we) m1_rdata <= resp_data;
                  end
               end
            end
            RESP: begin
               m0_ack      <= 1'b0;
               m0_err      <= 1'b0;
               m1_ack      <= 1'b0;
               m1_err      <= 1'b0;
               last_served <= grant_q[PORT_AUX];
               grant_q     <= 2'b00;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: main instance with TIMEOUT=8, second with TIMEOUT=4.
module tb_sdram_arbiter;

   logic        clk_50 = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [15:0] m0_addr, m1_addr;
   logic [7:0]  m0_wdata, m1_wdata;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [7:0]  m0_rdata, m1_rdata;
   logic [15:0] bus_address;
   logic        bus_read, bus_write, bus_byte_enable, bus_acknowledge;
   logic [7:0]  bus_write_data, bus_read_data;
   logic [1:0]  grant;
   logic        busy;

   logic        t_m0_req, t_m0_ack, t_m0_err, t_m1_ack, t_m1_err;
   logic [7:0]  t_m0_rdata, t_m1_rdata, t_bus_write_data, t_bus_read_data;
   logic [15:0] t_bus_address;
   logic        t_bus_read, t_bus_write, t_byte_en, t_bus_acknowledge, t_busy;
   logic [1:0]  t_grant;

   int total = 0;
   int bad   = 0;

   int          rd_cyc, wr_cyc, both, outside, acks0, acks1, first_s, ack_idx;
   logic [15:0] seen_addr;
   logic [7:0]  seen_wdata, rdata0, rdata1;
   logic        err0, err1;
   logic [1:0]  gq[$];

   always #10 clk_50 = ~clk_50;

   sdram_arbiter #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(8)) dut (
      .clk_50(clk_50), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
      .bus_write_data(bus_write_data), .bus_byte_enable(bus_byte_enable),
      .bus_acknowledge(bus_acknowledge), .bus_read_data(bus_read_data),
      .grant(grant), .busy(busy)
   );

   sdram_arbiter #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(4)) dut4 (
      .clk_50(clk_50), .rst(rst),
      .m0_req(t_m0_req), .m0_we(1'b0), .m0_addr(16'h4444), .m0_wdata(8'h00),
      .m0_ack(t_m0_ack), .m0_err(t_m0_err), .m0_rdata(t_m0_rdata),
      .m1_req(1'b0), .m1_we(1'b0), .m1_addr(16'h0000), .m1_wdata(8'h00),
      .m1_ack(t_m1_ack), .m1_err(t_m1_err), .m1_rdata(t_m1_rdata),
      .bus_address(t_bus_address), .bus_read(t_bus_read), .bus_write(t_bus_write),
      .bus_write_data(t_bus_write_data), .bus_byte_enable(t_byte_en),
      .bus_acknowledge(t_bus_acknowledge), .bus_read_data(t_bus_read_data),
      .grant(t_grant), .busy(t_busy)
   );

   // Bus responder and observer: acks on the lat-th strobe cycle (lat=0 never acks).
   task automatic run_bus(input int cycles, input int lat, input logic [7:0] rdv, input bit keep);
      int scnt = 0;
      rd_cyc = 0; wr_cyc = 0; both = 0; outside = 0; acks0 = 0; acks1 = 0;
      first_s = -1; ack_idx = -1; gq.delete();
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk_50);
         if (bus_read && bus_write) both++;
         if ((bus_read || bus_write) && (!busy || m0_ack || m1_ack)) outside++;
         if (bus_read || bus_write) begin
            if (first_s < 0) first_s = i;
            if (bus_read) rd_cyc++;
            if (bus_write) wr_cyc++;
            scnt++;
            if (scnt == 1) gq.push_back(grant);
            seen_addr  = bus_address;
            seen_wdata = bus_write_data;
            bus_acknowledge = (lat != 0 && scnt == lat);
            bus_read_data   = bus_acknowledge ? rdv : 8'h00;
         end else begin
            scnt = 0;
            bus_acknowledge = 1'b0;
         end
         if (m0_ack) begin
            acks0++; ack_idx = i; rdata0 = m0_rdata; err0 = m0_err;
            if (!keep) m0_req = 1'b0;
         end
         if (m1_ack) begin
            acks1++; ack_idx = i; rdata1 = m1_rdata; err1 = m1_err;
            if (!keep) m1_req = 1'b0;
         end
      end
      bus_acknowledge = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk_50);
      total++; if ({bus_read, bus_write} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b want 00", {bus_read, bus_write}); end
      total++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin bad++; $display("FAIL reset_acks: got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
      total++; if ({m0_rdata, m1_rdata} !== 16'h0000) begin bad++; $display("FAIL reset_rdata: got %h want 0000", {m0_rdata, m1_rdata}); end
      total++; if ({grant, busy} !== 3'b000) begin bad++; $display("FAIL reset_grant_busy: got %b want 000", {grant, busy}); end
      total++; if (bus_byte_enable !== 1'b1) begin bad++; $display("FAIL reset_byte_enable: got %b want 1", bus_byte_enable); end
      total++; if ({bus_address, bus_write_data} !== 24'h000000) begin bad++; $display("FAIL reset_bus: got %h want 000000", {bus_address, bus_write_data}); end
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      @(negedge clk_50);
      m0_we = 1'b0; m0_addr = 16'h1234; m0_req = 1'b1;
      run_bus(10, 3, 8'hA5, 1'b0);
      total++; if (rd_cyc !== 3) begin bad++; $display("FAIL read_strobe_len: got %0d want 3", rd_cyc); end
      total++; if (wr_cyc !== 0) begin bad++; $display("FAIL read_no_write: got %0d want 0", wr_cyc); end
      total++; if (seen_addr !== 16'h1234) begin bad++; $display("FAIL read_addr: got %h want 1234", seen_addr); end
      total++; if (first_s !== 0 || ack_idx !== 3) begin bad++; $display("FAIL read_latency: got strobe@%0d ack@%0d want 0 and 3", first_s, ack_idx); end
      total++; if (acks0 !== 1 || acks1 !== 0) begin bad++; $display("FAIL read_ack_count: got %0d/%0d want 1/0", acks0, acks1); end
      total++; if (rdata0 !== 8'hA5 || err0 !== 1'b0) begin bad++; $display("FAIL read_data: got %h err %b want a5 err 0", rdata0, err0); end
      total++; if (both !== 0 || outside !== 0) begin bad++; $display("FAIL read_strobe_rules: got both=%0d outside=%0d want 0/0", both, outside); end
   endtask

   task automatic test_single_write();
      @(negedge clk_50);
      m1_we = 1'b1; m1_addr = 16'h00FF; m1_wdata = 8'h3C; m1_req = 1'b1;
      run_bus(8, 1, 8'hEE, 1'b0);
      total++; if (wr_cyc !== 1 || rd_cyc !== 0) begin bad++; $display("FAIL write_strobes: got wr=%0d rd=%0d want 1/0", wr_cyc, rd_cyc); end
      total++; if (seen_addr !== 16'h00FF || seen_wdata !== 8'h3C) begin bad++; $display("FAIL write_bus: got %h/%h want 00ff/3c", seen_addr, seen_wdata); end
      total++; if (acks1 !== 1 || acks0 !== 0 || ack_idx !== 1) begin bad++; $display("FAIL write_ack: got %0d/%0d @%0d want 0/1 @1", acks0, acks1, ack_idx); end
      total++; if (rdata1 !== 8'h00 || err1 !== 1'b0) begin bad++; $display("FAIL write_rdata_kept: got %h err %b want 00 err 0", rdata1, err1); end
   endtask

   task automatic test_contention();
      bit repeat_seen = 0;
      @(negedge clk_50);
      rst = 1'b1;
      m0_we = 1'b0; m0_addr = 16'h0100; m0_req = 1'b1;
      m1_we = 1'b1; m1_addr = 16'h0200; m1_wdata = 8'h22; m1_req = 1'b1;
      @(negedge clk_50);
      rst = 1'b0;
      run_bus(40, 2, 8'h11, 1'b1);
      total++;
      if (gq.size() < 4) begin
         bad++; $display("FAIL contention_count: got %0d grants want >=4", gq.size());
      end else if (gq[0] !== 2'b01 || gq[1] !== 2'b10 || gq[2] !== 2'b01 || gq[3] !== 2'b10) begin
         bad++; $display("FAIL contention_order: got %b %b %b %b want 01 10 01 10", gq[0], gq[1], gq[2], gq[3]);
      end
      for (int i = 1; i < gq.size(); i++) if (gq[i] === gq[i-1]) repeat_seen = 1;
      total++; if (repeat_seen) begin bad++; $display("FAIL contention_repeat: got same port twice want alternation"); end
      total++; if (both !== 0 || outside !== 0) begin bad++; $display("FAIL contention_strobe_rules: got both=%0d outside=%0d want 0/0", both, outside); end
      m0_req = 1'b0; m1_req = 1'b0;
      run_bus(20, 2, 8'h00, 1'b0);
   endtask

   task automatic test_timeout();
      @(negedge clk_50);
      m0_we = 1'b0; m0_addr = 16'h0BAD; m0_req = 1'b1;
      run_bus(14, 0, 8'h00, 1'b0);
      total++; if (rd_cyc !== 8) begin bad++; $display("FAIL timeout_strobe_len: got %0d want 8", rd_cyc); end
      total++; if (acks0 !== 1 || ack_idx !== 8) begin bad++; $display("FAIL timeout_ack: got %0d @%0d want 1 @8", acks0, ack_idx); end
      total++; if (err0 !== 1'b1 || rdata0 !== 8'hFF) begin bad++; $display("FAIL timeout_err_data: got err %b data %h want 1 ff", err0, rdata0); end
      @(negedge clk_50);
      m1_we = 1'b0; m1_addr = 16'h0077; m1_req = 1'b1;
      run_bus(10, 2, 8'h77, 1'b0);
      total++; if (acks1 !== 1 || err1 !== 1'b0 || rdata1 !== 8'h77) begin bad++; $display("FAIL after_timeout_m1: got ack %0d err %b data %h want 1 0 77", acks1, err1, rdata1); end
   endtask

   task automatic test_reset_mid_issue();
      int late_acks = 0;
      @(negedge clk_50);
      m1_we = 1'b1; m1_addr = 16'hABCD; m1_wdata = 8'h99; m1_req = 1'b1;
      run_bus(3, 0, 8'h00, 1'b0);
      total++; if (wr_cyc !== 3) begin bad++; $display("FAIL midrst_pre: got %0d write cycles want 3", wr_cyc); end
      rst = 1'b1; m1_req = 1'b0;
      @(negedge clk_50);
      total++; if ({bus_read, bus_write, grant, m0_ack, m1_ack, busy} !== 7'b0) begin bad++; $display("FAIL midrst_clear: got %b want 0000000", {bus_read, bus_write, grant, m0_ack, m1_ack, busy}); end
      total++; if (m1_rdata !== 8'h00) begin bad++; $display("FAIL midrst_rdata: got %h want 00", m1_rdata); end
      rst = 1'b0; bus_acknowledge = 1'b1; bus_read_data = 8'h55;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_50);
         bus_acknowledge = 1'b0;
         if (m0_ack || m1_ack || busy) late_acks++;
      end
      total++; if (late_acks !== 0) begin bad++; $display("FAIL midrst_late_ack: got %0d responses want 0", late_acks); end
   endtask

   task automatic test_ack_at_timeout();
      int sc = 0, n = 0, wr_seen = 0;
      logic e = 1'b1;
      logic [7:0] d = 8'h00;
      logic [15:0] a = 16'h0000;
      @(negedge clk_50);
      t_m0_req = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_50);
         if (t_bus_write) wr_seen++;
         if (t_bus_read) begin
            sc++; a = t_bus_address;
            t_bus_acknowledge = (sc == 4);
            t_bus_read_data   = t_bus_acknowledge ? 8'h5A : 8'h00;
         end else t_bus_acknowledge = 1'b0;
         if (t_m0_ack) begin n++; e = t_m0_err; d = t_m0_rdata; t_m0_req = 1'b0; end
      end
      total++; if (sc !== 4 || wr_seen !== 0 || a !== 16'h4444) begin bad++; $display("FAIL tie_strobe: got %0d rd %0d wr addr %h want 4 0 4444", sc, wr_seen, a); end
      total++; if (n !== 1 || e !== 1'b0 || d !== 8'h5A) begin bad++; $display("FAIL tie_ack_wins: got ack %0d err %b data %h want 1 0 5a", n, e, d); end
      total++; if ({t_m1_ack, t_m1_err, t_m1_rdata, t_grant, t_busy, t_bus_write_data, t_byte_en} !== 21'h000001) begin
         bad++; $display("FAIL tie_idle_quiet: got %h want 000001", {t_m1_ack, t_m1_err, t_m1_rdata, t_grant, t_busy, t_bus_write_data, t_byte_en});
      end
   endtask

   initial begin
      rst = 1'b1;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
      bus_acknowledge = 1'b0; bus_read_data = '0;
      t_m0_req = 1'b0; t_bus_acknowledge = 1'b0; t_bus_read_data = '0;
      test_reset();
      test_single_read();
      test_single_write();
      test_contention();
      test_timeout();
      test_reset_mid_issue();
      test_ack_at_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
